// File: rtl/cnn_bram_loader.sv
// Stream-to-BRAM write front end for the CONV/max-pool controller.
// Each load command fills one contiguous segment and can optionally pulse the controller's start.
module cnn_bram_loader #(
  parameter int WIDTH      = 8,
  parameter int MEMADDRBIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [MEMADDRBIT-1:0] cfg_base,
  input  logic [MEMADDRBIT:0]   cfg_len,
  input  logic                  cfg_start,
  input  logic                  s_valid,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  s_ready,
  output logic                  wea,
  output logic [MEMADDRBIT-1:0] memaddr,
  output logic [WIDTH-1:0]      mem_in,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  cfg_err,
  output logic                  ctl_start
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  // One past the last addressable word; a segment may end exactly here.
  localparam logic [MEMADDRBIT+1:0] MEM_WORDS = {2'b01, {MEMADDRBIT{1'b0}}};

  state_t                state_q, state_d;
  logic [MEMADDRBIT-1:0] addr_q, addr_d;
  logic [MEMADDRBIT:0]   remaining_q, remaining_d;
  logic                  start_en_q, start_en_d;
  logic                  s_ready_q, s_ready_d;
  logic                  wea_q, wea_d;
  logic [MEMADDRBIT-1:0] memaddr_q, memaddr_d;
  logic [WIDTH-1:0]      mem_in_q, mem_in_d;
  logic                  load_busy_q, load_busy_d;
  logic                  load_done_q, load_done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  ctl_start_q, ctl_start_d;

  logic [MEMADDRBIT+1:0] cfg_end;
  logic                  beat;

  assign cfg_end = {2'b00, cfg_base} + {1'b0, cfg_len};
  assign beat    = s_valid & s_ready_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    start_en_d  = start_en_q;
    s_ready_d   = s_ready_q;
    wea_d       = 1'b0;
    memaddr_d   = memaddr_q;
    mem_in_d    = mem_in_q;
    load_busy_d = load_busy_q;
    load_done_d = 1'b0;
    cfg_err_d   = 1'b0;
    ctl_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_end > MEM_WORDS) begin
            cfg_err_d = 1'b1;
          end else if (cfg_len == '0) begin
            load_done_d = 1'b1;
            ctl_start_d = cfg_start;
          end else begin
            addr_d      = cfg_base;
            remaining_d = cfg_len;
            start_en_d  = cfg_start;
            s_ready_d   = 1'b1;
            load_busy_d = 1'b1;
            state_d     = LOAD;
          end
        end
      end

      LOAD: begin
        if (beat) begin
          wea_d       = 1'b1;
          memaddr_d   = addr_q;
          mem_in_d    = s_data;
          addr_d      = addr_q + MEMADDRBIT'(1);
          remaining_d = remaining_q - (MEMADDRBIT+1)'(1);
          if (remaining_q == (MEMADDRBIT+1)'(1)) begin
            s_ready_d = 1'b0;
            state_d   = FLUSH;
          end
        end
      end

      // Last write is on the port this cycle, so start is raised only after it lands.
      FLUSH: begin
        load_done_d = 1'b1;
        ctl_start_d = start_en_q;
        load_busy_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      start_en_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      wea_q       <= 1'b0;
      memaddr_q   <= '0;
      mem_in_q    <= '0;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      ctl_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      start_en_q  <= start_en_d;
      s_ready_q   <= s_ready_d;
      wea_q       <= wea_d;
      memaddr_q   <= memaddr_d;
      mem_in_q    <= mem_in_d;
      load_busy_q <= load_busy_d;
      load_done_q <= load_done_d;
      cfg_err_q   <= cfg_err_d;
      ctl_start_q <= ctl_start_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign wea       = wea_q;
  assign memaddr   = memaddr_q;
  assign mem_in    = mem_in_q;
  assign load_busy = load_busy_q;
  assign load_done = load_done_q;
  assign cfg_err   = cfg_err_q;
  assign ctl_start = ctl_start_q;

endmodule

// File: tb/tb_cnn_bram_loader.sv
// Randomized bench for cnn_bram_loader: a segment-level model predicts handshake, writes and pulses per cycle.
module tb_cnn_bram_loader;
  localparam int WIDTH     = 8;
  localparam int AW        = 17;
  localparam int MEM_WORDS = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [AW-1:0]    cfg_base;
  logic [AW:0]      cfg_len;
  logic             cfg_start;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             wea;
  logic [AW-1:0]    memaddr;
  logic [WIDTH-1:0] mem_in;
  logic             load_busy;
  logic             load_done;
  logic             cfg_err;
  logic             ctl_start;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] bram [MEM_WORDS];
  int wr_count    = 0;
  int done_count  = 0;
  int start_count = 0;

  always #5 clk = ~clk;

  cnn_bram_loader #(.WIDTH(WIDTH), .MEMADDRBIT(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wea       (wea),
    .memaddr   (memaddr),
    .mem_in    (mem_in),
    .load_busy (load_busy),
    .load_done (load_done),
    .cfg_err   (cfg_err),
    .ctl_start (ctl_start)
  );

  // BRAM image and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      bram[memaddr] = mem_in;
      wr_count++;
    end
    if (load_done === 1'b1) done_count++;
    if (ctl_start === 1'b1) start_count++;
  end

  // Cycle k=0 issues the command; beat offered in cycle k lands on the port in cycle k+1.
  task automatic run_segment(input string name, input int base, input int len, input bit start,
                             input int valid_pct, input int inject_at, input bit addr_data);
    bit               bad, ok, finished, prev_acc, sv;
    int               n_acc, last_cyc, budget, wr_start;
    logic [AW-1:0]    prev_addr;
    logic [WIDTH-1:0] prev_data, d;
    logic [5:0]       exp_f, got_f;
    bad       = (base + len) > MEM_WORDS;
    ok        = !bad && (len != 0);
    n_acc     = 0;
    last_cyc  = -10;
    prev_acc  = 1'b0;
    finished  = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    budget    = 4 * len + 20;
    wr_start  = wr_count;
    for (int k = 0; k < budget && !finished; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        exp_f[5] = ok && (n_acc < len);
        exp_f[4] = prev_acc;
        exp_f[3] = ok && ((n_acc < len) || (k == last_cyc + 1));
        exp_f[2] = (ok && k == last_cyc + 2) || (!bad && len == 0 && k == 1);
        exp_f[1] = exp_f[2] && start;
        exp_f[0] = bad && (k == 1);
        got_f = {s_ready, wea, load_busy, load_done, ctl_start, cfg_err};
        n_vec++;
        if (got_f !== exp_f) begin
          n_err++;
          $display("FAIL %s cycle %0d flags{rdy,wea,busy,done,start,err}: got %b expected %b",
                   name, k, got_f, exp_f);
        end
        if (prev_acc) begin
          n_vec++;
          if ({memaddr, mem_in} !== {prev_addr, prev_data}) begin
            n_err++;
            $display("FAIL %s cycle %0d write: got addr %0d data %h expected addr %0d data %h",
                     name, k, memaddr, mem_in, prev_addr, prev_data);
          end
        end
        finished = ok ? (k == last_cyc + 3) : (k == 3);
      end
      cfg_valid = (k == 0) || (k == inject_at);
      cfg_base  = (k == 0) ? AW'(base) : AW'(1061);
      cfg_len   = (k == 0) ? (AW+1)'(len) : (AW+1)'(40);
      cfg_start = (k == 0) ? start : 1'b1;
      sv        = (k > 0) && ($urandom_range(99) < valid_pct);
      d         = addr_data ? WIDTH'(base + n_acc) : WIDTH'($urandom);
      s_valid   = sv;
      s_data    = d;
      prev_acc  = sv && ok && (n_acc < len);
      if (prev_acc) begin
        prev_addr = AW'(base + n_acc);
        prev_data = d;
        n_acc++;
        if (n_acc == len) last_cyc = k;
      end
    end
    cfg_valid = 1'b0;
    s_valid   = 1'b0;
    n_vec++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout: segment not finished within %0d cycles", name, budget);
    end
    n_vec++;
    if ((wr_count - wr_start) != (ok ? len : 0)) begin
      n_err++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_count - wr_start, ok ? len : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({s_ready, wea, load_busy, load_done, cfg_err, ctl_start, memaddr, mem_in} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got flags %b addr %0d data %h expected all zero",
               {s_ready, wea, load_busy, load_done, cfg_err, ctl_start}, memaddr, mem_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_image();
    int bad_words;
    run_segment("image", 2, 675, 1'b0, 100, -1, 1'b1);
    bad_words = 0;
    for (int a = 2; a <= 676; a++) if (bram[a] !== WIDTH'(a)) bad_words++;
    n_vec++;
    if (bad_words != 0) begin
      n_err++;
      $display("FAIL image_readback: got %0d wrong words expected 0", bad_words);
    end
  endtask

  task automatic test_weights();
    run_segment("weights", 677, 384, 1'b1, 50, -1, 1'b0);
  endtask

  task automatic test_range();
    run_segment("range_over", 131000, 600, 1'b0, 50, -1, 1'b0);
    run_segment("range_edge", 130472, 600, 1'b0, 60, -1, 1'b0);
    n_vec++;
    if (memaddr !== AW'(131071)) begin
      n_err++;
      $display("FAIL range_last_addr: got %0d expected 131071", memaddr);
    end
  endtask

  task automatic test_len_zero();
    run_segment("len_zero", 5, 0, 1'b1, 50, -1, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    int wr0, d0, s0;
    wr0 = wr_count;
    d0  = done_count;
    s0  = start_count;
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_base  = AW'(677);
    cfg_len   = (AW+1)'(384);
    cfg_start = 1'b1;
    s_valid   = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      s_valid   = 1'b1;
      s_data    = WIDTH'($urandom);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({s_ready, wea, load_busy, load_done, cfg_err, ctl_start, memaddr, mem_in} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_state: got flags %b addr %0d data %h expected all zero",
               {s_ready, wea, load_busy, load_done, cfg_err, ctl_start}, memaddr, mem_in);
    end
    n_vec++;
    if ((wr_count - wr0) != 100) begin
      n_err++;
      $display("FAIL mid_reset_writes: got %0d expected 100", wr_count - wr0);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if ({done_count - d0, start_count - s0} != 64'd0 || load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_pulses: got done %0d start %0d busy %b expected 0 0 0",
               done_count - d0, start_count - s0, load_busy);
    end
    run_segment("reload", 677, 384, 1'b1, 50, -1, 1'b0);
  endtask

  task automatic test_cfg_during_load();
    run_segment("cfg_in_load", 677, 384, 1'b1, 100, 150, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_base  = '0;
    cfg_len   = '0;
    cfg_start = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    test_reset();
    test_image();
    test_weights();
    test_range();
    test_len_zero();
    test_reset_mid_load();
    test_cfg_during_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
